fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the pipelined RV64I core.
- Owns the PC and issues requests to a valid/ready instruction memory with variable latency.
- Buffers in-order responses and presents instr/PC to decode.
- Obeys StallF/StallD from hazard detection and redirects on branch/jump resolved in decode, discarding in-flight wrong-path fetches.

---
 rtl/fetch_stage.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV64I instruction-fetch stage (PC, imem valid/ready requests, in-order
// response buffer, IF/ID register). Define FETCH_PERF_CNT_EN to add perf counters.
module fetch_stage #(
    parameter int unsigned     XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [31:0]     NOP_INSTR       = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [31:0]     instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pcplus4_D,
    output logic            valid_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_dropped,
    output logic [63:0]     perf_stallcyc
`endif
);

    localparam int unsigned   CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned   PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_buf_count;
    logic [PW-1:0]   r_shd_wr;
    logic [PW-1:0]   r_shd_rd;
    logic [PW-1:0]   r_buf_wr;
    logic [PW-1:0]   r_buf_rd;
    logic [XLEN-1:0] r_shd_pc    [MAX_OUTSTANDING];
    logic [XLEN-1:0] r_buf_pc    [MAX_OUTSTANDING];
    logic [31:0]     r_buf_instr [MAX_OUTSTANDING];
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pcplus4_d;
    logic            r_valid_d;

    logic [CW-1:0]   w_occupancy;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_resp_fire;
    logic            w_resp_keep;
    logic            w_buf_empty;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_resp_pc;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [CW-1:0]   w_buf_count_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : PW'(p + 1'b1);
    endfunction

    // Occupancy counts in-flight requests plus buffered responses so no response can overflow.
    assign w_occupancy = r_outstanding + r_buf_count;
    assign w_req_valid = !rst && !StallF && !redirect_valid && (w_occupancy < MAX_CNT);
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_resp_fire = imem_resp_valid && (r_outstanding != '0);
    assign w_resp_keep = w_resp_fire && (r_drop_cnt == '0) && !redirect_valid;
    assign w_buf_empty = (r_buf_count == '0);
    assign w_bypass    = w_resp_keep && w_buf_empty && !StallD;
    assign w_push      = w_resp_keep && !w_bypass;
    assign w_pop       = !redirect_valid && !StallD && !w_buf_empty;
    assign w_resp_pc   = r_shd_pc[r_shd_rd];

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_D        = r_instr_d;
    assign pc_D           = r_pc_d;
    assign pcplus4_D      = r_pcplus4_d;
    assign valid_D        = r_valid_d;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_drop_nxt        = r_drop_cnt;
        w_buf_count_nxt   = r_buf_count;
        if (w_req_fire && !w_resp_fire) begin
            w_outstanding_nxt = r_outstanding + 1'b1;
        end else if (!w_req_fire && w_resp_fire) begin
            w_outstanding_nxt = r_outstanding - 1'b1;
        end
        // Every request still in flight after a redirect is wrong-path.
        if (redirect_valid) begin
            w_drop_nxt = w_resp_fire ? (r_outstanding - 1'b1) : r_outstanding;
        end else if (w_resp_fire && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - 1'b1;
        end
        if (redirect_valid) begin
            w_buf_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_buf_count_nxt = r_buf_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_buf_count_nxt = r_buf_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_buf_count   <= '0;
            r_shd_wr      <= '0;
            r_shd_rd      <= '0;
            r_buf_wr      <= '0;
            r_buf_rd      <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_buf_count   <= w_buf_count_nxt;
            if (redirect_valid) begin
                r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_req_fire) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_req_fire) begin
                r_shd_wr <= ptr_inc(r_shd_wr);
            end
            if (w_resp_fire) begin
                r_shd_rd <= ptr_inc(r_shd_rd);
            end
            if (redirect_valid) begin
                r_buf_wr <= '0;
                r_buf_rd <= '0;
            end else begin
                if (w_push) begin
                    r_buf_wr <= ptr_inc(r_buf_wr);
                end
                if (w_pop) begin
                    r_buf_rd <= ptr_inc(r_buf_rd);
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_shd_pc[r_shd_wr] <= r_pc;
        end
        if (w_push) begin
            r_buf_instr[r_buf_wr] <= imem_resp_data;
            r_buf_pc[r_buf_wr]    <= w_resp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (redirect_valid || (!StallD && w_buf_empty && !w_bypass)) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (!StallD) begin
            r_valid_d <= 1'b1;
            if (!w_buf_empty) begin
                r_instr_d   <= r_buf_instr[r_buf_rd];
                r_pc_d      <= r_buf_pc[r_buf_rd];
                r_pcplus4_d <= r_buf_pc[r_buf_rd] + XLEN'(4);
            end else begin
                r_instr_d   <= imem_resp_data;
                r_pc_d      <= w_resp_pc;
                r_pcplus4_d <= w_resp_pc + XLEN'(4);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] r_perf_fetched;
    logic [63:0] r_perf_dropped;
    logic [63:0] r_perf_stallcyc;

    assign perf_fetched  = r_perf_fetched;
    assign perf_dropped  = r_perf_dropped;
    assign perf_stallcyc = r_perf_stallcyc;

    // Saturating counters; "dropped" covers every discarded wrong-path response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched  <= '0;
            r_perf_dropped  <= '0;
            r_perf_stallcyc <= '0;
        end else begin
            if (w_resp_keep && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 64'd1;
            end
            if (w_resp_fire && !w_resp_keep && (r_perf_dropped != '1)) begin
                r_perf_dropped <= r_perf_dropped + 64'd1;
            end
            if (StallF && (r_perf_stallcyc != '1)) begin
                r_perf_stallcyc <= r_perf_stallcyc + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage; a queue-based model of requests,
// responses and the IF/ID register predicts every output each cycle.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam int unsigned     XLEN   = 64;
    localparam int unsigned     MAXO   = 2;
    localparam logic [XLEN-1:0] RST_PC = 64'h0000_0000_0000_1000;
    localparam logic [31:0]     NOP    = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            StallF;
    logic            StallD;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic [31:0]     instr_D;
    logic [XLEN-1:0] pc_D;
    logic [XLEN-1:0] pcplus4_D;
    logic            valid_D;

    fetch_stage #(
        .XLEN(XLEN), .RESET_PC(RST_PC), .MAX_OUTSTANDING(MAXO), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .instr_D(instr_D), .pc_D(pc_D),
        .pcplus4_D(pcplus4_D), .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; bit wrong; int due; } req_t;
    typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;

    req_t        outq[$];
    ent_t        bufq[$];
    logic [63:0] m_pc;
    logic [63:0] m_pc_d;
    logic [31:0] m_instr;
    logic        m_vld;
    int          cyc = 0;
    bit          force_spur = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Random phases: StallF%, StallD%, redirect%, ready%, resp%, spurious-resp%
    int tbl [5][6] = '{
        '{10, 10,  5, 70, 60, 5},
        '{ 0, 40,  3, 90, 90, 0},
        '{30,  0,  8, 50, 40, 10},
        '{ 5,  5, 15, 100, 100, 5},
        '{20, 30, 10, 30, 30, 10}
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit roll(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h9E37_79B9;
    endfunction

    task automatic model_reset();
        outq.delete();
        bufq.delete();
        m_pc    = RST_PC;
        m_pc_d  = '0;
        m_instr = NOP;
        m_vld   = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
        chk({tag, "_valid_D"}, valid_D, 1'b0);
        chk({tag, "_instr_D"}, instr_D, NOP);
        chk({tag, "_pc_D"}, pc_D, 64'd0);
        chk({tag, "_pcplus4_D"}, pcplus4_D, 64'd0);
    endtask

    // One clock cycle: drive, check predicted outputs, advance the model across the edge.
    task automatic run_cycle(input int pf, input int pd, input int pr, input int prdy,
                             input int presp, input int pspur, input logic [63:0] rpc);
        logic exp_rv;
        bit   fire;
        bit   resp;
        bit   keep;
        req_t e;
        ent_t b;
        StallF         = roll(pf);
        StallD         = roll(pd);
        redirect_valid = roll(pr);
        redirect_pc    = (rpc != 64'd0) ? rpc : {$urandom, $urandom};
        imem_req_ready = roll(prdy);
        if (outq.size() > 0) begin
            imem_resp_valid = (outq[0].due <= cyc) && roll(presp);
            imem_resp_data  = mem_word(outq[0].pc);
        end else begin
            imem_resp_valid = force_spur || roll(pspur);
            imem_resp_data  = $urandom;
        end
        force_spur = 0;
        #2;
        exp_rv = !StallF && !redirect_valid && ((outq.size() + bufq.size()) < MAXO);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, m_pc);
        chk("valid_D", valid_D, m_vld);
        chk("instr_D", instr_D, m_instr);
        if (m_vld) begin
            chk("pc_D", pc_D, m_pc_d);
            chk("pcplus4_D", pcplus4_D, m_pc_d + 64'd4);
        end

        fire = exp_rv && imem_req_ready;
        resp = imem_resp_valid && (outq.size() > 0);
        keep = 0;
        if (resp) begin
            e    = outq.pop_front();
            keep = !e.wrong && !redirect_valid;
        end
        if (fire) outq.push_back('{pc: m_pc, wrong: 1'b0, due: cyc + 1});
        if (redirect_valid) begin
            foreach (outq[i]) outq[i].wrong = 1'b1;
            m_pc = {redirect_pc[63:2], 2'b00};
            bufq.delete();
            m_vld   = 1'b0;
            m_instr = NOP;
        end else begin
            if (fire) m_pc = m_pc + 64'd4;
            if (keep) bufq.push_back('{instr: mem_word(e.pc), pc: e.pc});
            if (!StallD) begin
                if (bufq.size() > 0) begin
                    b       = bufq.pop_front();
                    m_instr = b.instr;
                    m_pc_d  = b.pc;
                    m_vld   = 1'b1;
                end else begin
                    m_instr = NOP;
                    m_vld   = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic normal(input int n);
        repeat (n) run_cycle(0, 0, 0, 100, 100, 0, 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        StallF          = 1'b0;
        StallD          = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #3;
        reset_checks("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        normal(12);
        repeat (3) run_cycle(100, 100, 0, 100, 100, 0, 64'd0);
        normal(6);
        // Two wrong-path requests in flight, then redirect to 0x3000.
        repeat (3) run_cycle(0, 0, 0, 100, 0, 0, 64'd0);
        run_cycle(0, 0, 100, 100, 0, 0, 64'h3000);
        normal(8);
        // Memory stalls the request, redirect arrives during the wait.
        repeat (4) run_cycle(0, 0, 0, 0, 100, 0, 64'd0);
        run_cycle(0, 0, 100, 0, 100, 0, 64'h3000);
        normal(6);
        repeat (8) run_cycle(0, 100, 0, 100, 100, 0, 64'd0);
        normal(6);
        // Misaligned target near the top of the address space exercises PC wrap.
        run_cycle(0, 0, 100, 100, 100, 0, 64'hFFFF_FFFF_FFFF_FFFA);
        normal(8);

        foreach (tbl[i]) begin
            repeat (400) run_cycle(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3],
                                   tbl[i][4], tbl[i][5], 64'd0);
        end

        // Async reset with responses still in flight; a late response must be ignored.
        normal(3);
        repeat (2) run_cycle(0, 0, 0, 100, 0, 0, 64'd0);
        StallF          = 1'b0;
        StallD          = 1'b0;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        reset_checks("mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        force_spur = 1;
        normal(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
